// File: rtl/ibex_wb_pkg.sv
// rtl/ibex_wb_pkg.sv - shared types and helpers for the register file writeback controller
//
// Purpose: staged write request type, outstanding-load limit and the
// register address legality check shared by the writeback controller files.
// Ports: none (package).

package ibex_wb_pkg;

  // Upper bound on the outstanding-load destination FIFO depth.
  localparam int unsigned NumOutstandingMax = 4;

  // Width of the data field carried in a staged write request.
  localparam int unsigned WbDataWidth = 32;

  typedef struct packed {
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
    logic                   we;
  } wb_req_t;

  // RV32E only implements x0..x15; any address with bit 4 set is outside it.
  function automatic logic rf_addr_legal(input logic [4:0] addr, input bit rv32e);
    return !(rv32e && addr[4]);
  endfunction

endpackage

// File: rtl/ibex_wb_ld_fifo.sv
// rtl/ibex_wb_ld_fifo.sv - in-order FIFO of outstanding load destination addresses
//
// Purpose: remembers the destination register of every load handed to the
// LSU, in issue order, and exposes every slot so hazards can be detected.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          store push_addr_i at the tail (ignored when full)
//   push_addr_i     destination register of the issued load
//   pop_i           drop the head entry (ignored when empty)
//   full_o/empty_o  occupancy flags
//   head_o          destination of the oldest outstanding load
//   valid_o/addr_o  per-slot occupancy and destination address

module ibex_wb_ld_fifo #(
  parameter int unsigned Depth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [4:0]            push_addr_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [4:0]            head_o,
  output logic [Depth-1:0]      valid_o,
  output logic [Depth-1:0][4:0] addr_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [Depth-1:0]      valid_q;
  logic [Depth-1:0][4:0] addr_q;
  logic                  push, pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = &valid_q;
  assign empty_o = ~|valid_q;

  // Push is only possible when not full and pop only when not empty, so a
  // simultaneous push and pop always targets two different slots.
  assign push = push_i && !full_o;
  assign pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      addr_q   <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q]  <= push_addr_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= next_ptr(rd_ptr_q);
      end
    end
  end

  assign head_o  = addr_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/ibex_rf_writeback_ctrl.sv
// rtl/ibex_rf_writeback_ctrl.sv - register file write port arbiter, load tracker and forwarder
//
// Purpose: merges single-cycle EX results and variable-latency LSU load
// responses into one registered register-file write per cycle, tracks the
// destinations of outstanding loads for load-use stalls and forwards the
// staged write to the read ports.
// Optional feature macro: IBEX_WB_DUMMY_R0_EN (adds ex_dummy_i; an EX result
// flagged dummy with destination x0 writes the register file's dummy r0).
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o              EX result handshake
//   ex_waddr_i/ex_wdata_i              EX destination and result
//   ex_dummy_i                         dummy-r0 write request (macro only)
//   ld_issue_i/ld_waddr_i              load issue and its destination
//   ld_issue_ready_o                   a tracking slot is free
//   lsu_rvalid_i/lsu_rdata_i/lsu_err_i load response
//   rf_waddr_o/rf_wdata_o/rf_we_o      register file write port
//   raddr_a_i/raddr_b_i                decode read addresses
//   hazard_a_o/hazard_b_o              read address waits on an outstanding load
//   fwd_a_o/fwd_b_o/fwd_data_o         bypass of the staged write
//   ld_err_o                           pulse after an errored load response
//   spurious_o                         pulse after a response with nothing outstanding

module ibex_rf_writeback_ctrl
  import ibex_wb_pkg::*;
#(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 2   // 1..NumOutstandingMax
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
`ifdef IBEX_WB_DUMMY_R0_EN
  input  logic                 ex_dummy_i,
`endif
  input  logic                 ld_issue_i,
  input  logic [4:0]           ld_waddr_i,
  output logic                 ld_issue_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [DataWidth-1:0] fwd_data_o,
  output logic                 ld_err_o,
  output logic                 spurious_o
);

  logic                           fifo_full, fifo_empty;
  logic [4:0]                     fifo_head;
  logic [NumOutstanding-1:0]      fifo_valid;
  logic [NumOutstanding-1:0][4:0] fifo_addr;
  logic                           fifo_push, fifo_pop;
  logic                           ex_accept, ex_dummy_r0;
  logic                           hazard_a, hazard_b;
  wb_req_t                        wb_d, wb_q;
  logic                           ld_err_q, spurious_q;

  // --------------------------------------------------------------------------
  // Outstanding-load tracking
  // --------------------------------------------------------------------------
  assign ld_issue_ready_o = !fifo_full;
  assign fifo_push        = ld_issue_i && !fifo_full;
  assign fifo_pop         = lsu_rvalid_i && !fifo_empty;

  ibex_wb_ld_fifo #(
    .Depth (NumOutstanding)
  ) u_ld_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_addr_i (ld_waddr_i),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .addr_o      (fifo_addr)
  );

  // --------------------------------------------------------------------------
  // Arbitration: a real load response owns the write port; a response with
  // nothing outstanding does not, so it never stalls EX.
  // --------------------------------------------------------------------------
  assign ex_ready_o = !fifo_pop;
  assign ex_accept  = ex_valid_i && ex_ready_o;

`ifdef IBEX_WB_DUMMY_R0_EN
  assign ex_dummy_r0 = ex_dummy_i && (ex_waddr_i == 5'd0);
`else
  assign ex_dummy_r0 = 1'b0;
`endif

  // Address and data follow every accepted result, even one that does not
  // write (x0, illegal RV32E address); they hold otherwise while we drops.
  // An errored load response is not an accepted result.
  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    if (fifo_pop) begin
      if (!lsu_err_i) begin
        wb_d.addr = fifo_head;
        wb_d.data = WbDataWidth'(lsu_rdata_i);
        wb_d.we   = (fifo_head != 5'd0) && rf_addr_legal(fifo_head, RV32E);
      end
    end else if (ex_accept) begin
      wb_d.addr = ex_waddr_i;
      wb_d.data = WbDataWidth'(ex_wdata_i);
      wb_d.we   = ((ex_waddr_i != 5'd0) && rf_addr_legal(ex_waddr_i, RV32E)) || ex_dummy_r0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_q       <= '0;
      ld_err_q   <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      ld_err_q   <= fifo_pop && lsu_err_i;
      spurious_q <= lsu_rvalid_i && fifo_empty;
    end
  end

  assign rf_waddr_o = wb_q.addr;
  assign rf_wdata_o = DataWidth'(wb_q.data);
  assign rf_we_o    = wb_q.we;
  assign ld_err_o   = ld_err_q;
  assign spurious_o = spurious_q;

  // --------------------------------------------------------------------------
  // Hazards: every occupied slot counts, including the head being popped this
  // cycle, because its data is not in the register file until the next cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < int'(NumOutstanding); i++) begin
      if (fifo_valid[i] && (fifo_addr[i] == raddr_a_i)) hazard_a = 1'b1;
      if (fifo_valid[i] && (fifo_addr[i] == raddr_b_i)) hazard_b = 1'b1;
    end
  end

  assign hazard_a_o = hazard_a && (raddr_a_i != 5'd0);
  assign hazard_b_o = hazard_b && (raddr_b_i != 5'd0);

  // --------------------------------------------------------------------------
  // Forwarding: the register file only holds the staged value one cycle
  // later. x0 is never forwarded, even when a dummy-r0 write is staged.
  // --------------------------------------------------------------------------
  assign fwd_a_o    = rf_we_o && (rf_waddr_o == raddr_a_i) && (raddr_a_i != 5'd0);
  assign fwd_b_o    = rf_we_o && (rf_waddr_o == raddr_b_i) && (raddr_b_i != 5'd0);
  assign fwd_data_o = rf_wdata_o;

endmodule

// File: tb/tb_ibex_rf_writeback_ctrl.sv
// tb/tb_ibex_rf_writeback_ctrl.sv - self-checking bench for ibex_rf_writeback_ctrl

module tb_ibex_rf_writeback_ctrl;

  localparam int NOut = 2;
`ifdef IBEX_WB_DUMMY_R0_EN
  localparam bit DummyEn = 1'b1;
`else
  localparam bit DummyEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic        ex_valid, ex_dummy, ld_issue, rvalid, err;
  logic [4:0]  ex_waddr, ld_waddr, raddr_a, raddr_b;
  logic [31:0] ex_wdata, rdata;

  logic        ex_ready, ld_ready, rf_we, haz_a, haz_b, fwd_a, fwd_b, ld_err, spur;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fwd_data;

  logic        e_ex_ready, e_ld_ready, e_rf_we, e_haz_a, e_haz_b, e_fwd_a, e_fwd_b, e_ld_err, e_spur;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata, e_fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_rf_writeback_ctrl #(.RV32E(1'b0), .DataWidth(32), .NumOutstanding(NOut)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
`ifdef IBEX_WB_DUMMY_R0_EN
    .ex_dummy_i(ex_dummy),
`endif
    .ld_issue_i(ld_issue), .ld_waddr_i(ld_waddr), .ld_issue_ready_o(ld_ready),
    .lsu_rvalid_i(rvalid), .lsu_rdata_i(rdata), .lsu_err_i(err),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(haz_a), .hazard_b_o(haz_b), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .fwd_data_o(fwd_data), .ld_err_o(ld_err), .spurious_o(spur)
  );

  ibex_rf_writeback_ctrl #(.RV32E(1'b1), .DataWidth(32), .NumOutstanding(NOut)) u_dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(e_ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
`ifdef IBEX_WB_DUMMY_R0_EN
    .ex_dummy_i(ex_dummy),
`endif
    .ld_issue_i(ld_issue), .ld_waddr_i(ld_waddr), .ld_issue_ready_o(e_ld_ready),
    .lsu_rvalid_i(rvalid), .lsu_rdata_i(rdata), .lsu_err_i(err),
    .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .rf_we_o(e_rf_we),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(e_haz_a), .hazard_b_o(e_haz_b), .fwd_a_o(e_fwd_a), .fwd_b_o(e_fwd_b),
    .fwd_data_o(e_fwd_data), .ld_err_o(e_ld_err), .spurious_o(e_spur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed, input logic dm,
                       input logic li, input logic [4:0] la, input logic rv, input logic [31:0] rd,
                       input logic er, input logic [4:0] ra, input logic [4:0] rb);
    ex_valid = ev; ex_waddr = ea; ex_wdata = ed; ex_dummy = dm;
    ld_issue = li; ld_waddr = la; rvalid = rv; rdata = rd; err = er;
    raddr_a = ra; raddr_b = rb;
  endtask

  typedef struct {
    logic        ev; logic [4:0] ea; logic [31:0] ed; logic dm;
    logic        li; logic [4:0] la; logic rv; logic [31:0] rd; logic er; logic [4:0] ra;
    logic        x_exr, x_ldr, x_haz, x_fwd;
    logic        x_we; logic [4:0] x_wa; logic [31:0] x_wd; logic x_err, x_spur, x_we_e;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ev, ea, ed, dm, li, la, rv, rd, er, ra,
                              input logic [31:0] xr, xl, xh, xf, xw, xa, xd, xe, xs, xwe);
    vec_t v;
    v.ev = ev[0]; v.ea = 5'(ea); v.ed = ed; v.dm = dm[0];
    v.li = li[0]; v.la = 5'(la); v.rv = rv[0]; v.rd = rd; v.er = er[0]; v.ra = 5'(ra);
    v.x_exr = xr[0]; v.x_ldr = xl[0]; v.x_haz = xh[0]; v.x_fwd = xf[0];
    v.x_we = xw[0]; v.x_wa = 5'(xa); v.x_wd = xd; v.x_err = xe[0]; v.x_spur = xs[0]; v.x_we_e = xwe[0];
    return v;
  endfunction

  vec_t tbl[21];

  // Reference model state: queue of outstanding destinations plus the staged write.
  logic [4:0]  mq[$];
  logic        m_we, m_we_e, m_err, m_spur;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic logic m_writes(input logic [4:0] a, input bit rv32e, input logic dm, input bit is_ex);
    if (a == 0) return is_ex && DummyEn && dm;
    return !(rv32e && a >= 16);
  endfunction

  function automatic logic m_haz(input logic [4:0] ra);
    if (ra == 0) return 1'b0;
    foreach (mq[k]) if (mq[k] == ra) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    // Columns: ex_valid, ex_waddr, ex_wdata, dummy, ld_issue, ld_waddr, rvalid, rdata, err, raddr_a |
    //          ex_ready, ld_ready, hazard_a, fwd_a | we, waddr, wdata, ld_err, spurious, we(RV32E)
    tbl[0]  = mk(0, 0, 0, 0,            0, 0,  0, 0, 0,      0,  1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,  0, 0, 0,      5,  1, 1, 0, 0,  1, 5, 32'hDEADBEEF, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0,            0, 0,  0, 0, 0,      5,  1, 1, 0, 1,  0, 5, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,            1, 7,  0, 0, 0,      7,  1, 1, 0, 0,  0, 5, 32'hDEADBEEF, 0, 0, 0);
    tbl[4]  = mk(1, 3, 32'h11, 0,       0, 0,  1, 32'h22, 0, 7,  0, 1, 1, 0,  1, 7, 32'h22, 0, 0, 1);
    tbl[5]  = mk(1, 3, 32'h11, 0,       0, 0,  0, 0, 0,      7,  1, 1, 0, 1,  1, 3, 32'h11, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0,            1, 4,  0, 0, 0,      3,  1, 1, 0, 1,  0, 3, 32'h11, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,            1, 9,  0, 0, 0,      9,  1, 1, 0, 0,  0, 3, 32'h11, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,            1, 12, 0, 0, 0,      9,  1, 0, 1, 0,  0, 3, 32'h11, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,            0, 0,  1, 32'h44, 0, 4,  0, 0, 1, 0,  1, 4, 32'h44, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0,            0, 0,  1, 32'h99, 0, 9,  0, 1, 1, 0,  1, 9, 32'h99, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0,            0, 0,  0, 0, 0,      9,  1, 1, 0, 1,  0, 9, 32'h99, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,            1, 6,  0, 0, 0,      6,  1, 1, 0, 0,  0, 9, 32'h99, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,            0, 0,  1, 32'h55, 1, 6,  0, 1, 1, 0,  0, 9, 32'h99, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,            0, 0,  1, 32'h66, 0, 6,  1, 1, 0, 0,  0, 9, 32'h99, 0, 1, 0);
    tbl[15] = mk(1, 0, 32'h77, 1,       0, 0,  0, 0, 0,      0,  1, 1, 0, 0,  DummyEn, 0, 32'h77, 0, 0, DummyEn);
    tbl[16] = mk(1, 20, 32'hAB, 0,      0, 0,  0, 0, 0,      20, 1, 1, 0, 0,  1, 20, 32'hAB, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,            0, 0,  0, 0, 0,      20, 1, 1, 0, 1,  0, 20, 32'hAB, 0, 0, 0);
    tbl[18] = mk(1, 5, 32'h5A, 0,       0, 0,  1, 32'hFF, 0, 5,  1, 1, 0, 0,  1, 5, 32'h5A, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0,            1, 0,  0, 0, 0,      0,  1, 1, 0, 0,  0, 5, 32'h5A, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,            0, 0,  1, 32'h33, 0, 0,  0, 1, 0, 0,  0, 0, 32'h33, 0, 0, 0);

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_we", rf_we, 0);       chk("reset_waddr", rf_waddr, 0);
    chk("reset_wdata", rf_wdata, 0); chk("reset_ld_err", ld_err, 0);
    chk("reset_spur", spur, 0);      chk("reset_ld_ready", ld_ready, 1);
    chk("reset_ex_ready", ex_ready, 1);
    chk("reset_haz", {haz_a, haz_b}, 0); chk("reset_fwd", {fwd_a, fwd_b}, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].dm, tbl[i].li, tbl[i].la,
            tbl[i].rv, tbl[i].rd, tbl[i].er, tbl[i].ra, 5'd0);
      #1;
      chk($sformatf("v%0d_ex_ready", i), ex_ready, tbl[i].x_exr);
      chk($sformatf("v%0d_ld_ready", i), ld_ready, tbl[i].x_ldr);
      chk($sformatf("v%0d_hazard_a", i), haz_a, tbl[i].x_haz);
      chk($sformatf("v%0d_fwd_a", i), fwd_a, tbl[i].x_fwd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), rf_we, tbl[i].x_we);
      chk($sformatf("v%0d_waddr", i), rf_waddr, tbl[i].x_wa);
      chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].x_wd);
      chk($sformatf("v%0d_ld_err", i), ld_err, tbl[i].x_err);
      chk($sformatf("v%0d_spurious", i), spur, tbl[i].x_spur);
      chk($sformatf("v%0d_we_rv32e", i), e_rf_we, tbl[i].x_we_e);
    end

    // Reset with two loads outstanding and a write staged
    drive(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 5, 32'hABC, 0, 1, 9, 0, 0, 0, 9, 4);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 4);
    #1;
    chk("rst_pre_we", rf_we, 1);
    chk("rst_pre_ld_ready", ld_ready, 0);
    chk("rst_pre_haz", {haz_a, haz_b}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_haz", {haz_a, haz_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 32'h1, 0, 9, 4);
    #1;
    chk("rst_post_ex_ready", ex_ready, 1);
    @(posedge clk); #1;
    chk("rst_post_spur", spur, 1);
    chk("rst_post_we", rf_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rst_post_spur_pulse", spur, 0);

    // Randomized run against the reference model
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    m_we = 0; m_we_e = 0; m_err = 0; m_spur = 0; m_wa = 0; m_wd = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] a_ex, a_ld, a_ra, a_rb;
      logic       pop, n_we, n_we_e;
      a_ex = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a_ld = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a_ra = 5'($urandom_range(0, 7));
      a_rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), a_ex, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 4), a_ld, 1'($urandom_range(0, 9) < 4), $urandom,
            1'($urandom_range(0, 7) == 0), a_ra, a_rb);
      #1;
      chk("rnd_ex_ready", ex_ready, !(rvalid && mq.size() != 0));
      chk("rnd_ld_ready", ld_ready, mq.size() < NOut);
      chk("rnd_hazard_a", haz_a, m_haz(raddr_a));
      chk("rnd_hazard_b", haz_b, m_haz(raddr_b));
      chk("rnd_fwd_a", fwd_a, m_we && m_wa == raddr_a && raddr_a != 0);
      chk("rnd_fwd_b", fwd_b, m_we && m_wa == raddr_b && raddr_b != 0);
      chk("rnd_fwd_data", fwd_data, m_wd);
      // next state of the model
      pop    = rvalid && mq.size() != 0;
      n_we   = 0;
      n_we_e = 0;
      m_spur = rvalid && mq.size() == 0;
      m_err  = pop && err;
      if (ld_issue && mq.size() < NOut) mq.push_back(ld_waddr);
      if (pop) begin
        logic [4:0] d;
        d = mq.pop_front();
        if (!err) begin
          m_wa = d; m_wd = rdata;
          n_we = m_writes(d, 0, 0, 0); n_we_e = m_writes(d, 1, 0, 0);
        end
      end else if (ex_valid) begin
        m_wa = ex_waddr; m_wd = ex_wdata;
        n_we = m_writes(ex_waddr, 0, ex_dummy, 1); n_we_e = m_writes(ex_waddr, 1, ex_dummy, 1);
      end
      m_we = n_we; m_we_e = n_we_e;
      @(posedge clk); #1;
      chk("rnd_we", rf_we, m_we);
      chk("rnd_waddr", rf_waddr, m_wa);
      chk("rnd_wdata", rf_wdata, m_wd);
      chk("rnd_ld_err", ld_err, m_err);
      chk("rnd_spurious", spur, m_spur);
      chk("rnd_we_rv32e", e_rf_we, m_we_e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_rf_writeback_ctrl.md
Name: ibex_rf_writeback_ctrl

Overview:
- Initiator side of the register file write port: owns the single `waddr_a/wdata_a/we_a` interface into the register file.
- Merges two result sources, single-cycle EX results and variable-latency LSU load responses, into one registered write per cycle.
- Tracks the destinations of outstanding loads so decode can stall on load-use hazards.
- Forwards the staged write value to the read ports, since the register file contents lag one cycle behind the write.

Parameters:
- RV32E, 0: 16-entry register file; destination addresses with bit 4 set are suppressed.
- DataWidth, 32: width of the data path.
- NumOutstanding, 2: depth of the outstanding-load destination FIFO; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX result valid
- ex_ready_o  out  1  EX result accepted this cycle
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  DataWidth  EX result
- ld_issue_i  in  1  load issued to LSU
- ld_waddr_i  in  5  load destination register
- ld_issue_ready_o  out  1  tracking slot free
- lsu_rvalid_i  in  1  load response valid
- lsu_rdata_i  in  DataWidth  load data
- lsu_err_i  in  1  load bus error, qualified by lsu_rvalid_i
- rf_waddr_o  out  5  write address to the register file
- rf_wdata_o  out  DataWidth  write data to the register file
- rf_we_o  out  1  write enable to the register file
- raddr_a_i / raddr_b_i  in  5  read addresses from decode
- hazard_a_o / hazard_b_o  out  1  read address matches an outstanding load
- fwd_a_o / fwd_b_o  out  1  use fwd_data_o in place of register file read data
- fwd_data_o  out  DataWidth  staged write data
- ld_err_o  out  1  one-cycle pulse on an errored load response
- spurious_o  out  1  one-cycle pulse on a response with no outstanding load

Behaviour:
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, ld_err_o=0, spurious_o=0, FIFO empty.
  - With an empty FIFO the combinational outputs follow: ld_issue_ready_o=1; hazards=0; fwd=0.
  - With lsu_rvalid_i low: ex_ready_o=1.
- Arbitration:
  - Load responses have priority.
  - ex_ready_o = !(lsu_rvalid_i && FIFO non-empty).
  - An EX result is accepted when ex_valid_i && ex_ready_o; otherwise EX holds.
- Write stage: one register stage, so a write reaches rf_* one cycle after acceptance.
  - rf_we_o=1 only if the accepted destination is nonzero and legal for RV32E.
  - rf_waddr_o and rf_wdata_o update on every acceptance. They hold when nothing is accepted; rf_we_o drops to 0.
- Load FIFO (in order):
  - Push on ld_issue_i && ld_issue_ready_o, where ld_issue_ready_o = !full.
  - Pop on lsu_rvalid_i when non-empty.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo NumOutstanding.
  - A pop writes the head's destination with lsu_rdata_i, unless lsu_err_i is set.
    - On error: no write, and ld_err_o pulses next cycle.
- Spurious response: lsu_rvalid_i with an empty FIFO is ignored; spurious_o pulses next cycle and the EX path is unaffected.
- Hazard: hazard_x_o = raddr_x nonzero && matches any valid FIFO entry, including the entry popped this cycle. Combinational.
- Forward: fwd_x_o = rf_we_o && rf_waddr_o == raddr_x && raddr_x != 0. Combinational.
- x0 loads still occupy a FIFO slot and are popped normally, but never write and never raise a hazard.
- Reset mid-operation: the FIFO is flushed and a staged write is dropped. Responses arriving after reset count as spurious.

Optional Feature:
- Macro: IBEX_WB_DUMMY_R0_EN.
- With the macro:
  - Input `ex_dummy_i` is added.
  - An EX result with ex_dummy_i=1 and destination 0 asserts rf_we_o with rf_waddr_o=0, feeding the register file's dummy-r0 storage.
  - fwd_x_o never asserts for address 0.
- Without the macro: writes to x0 never assert rf_we_o.

Decomposition:
- Shared package `ibex_wb_pkg`:
  - Typedef wb_req_t {addr[4:0], data, we}.
  - Constant NumOutstandingMax=4.
  - Function rf_addr_legal(addr, RV32E).
- Sub-module `ibex_wb_ld_fifo`: parameterised destination-address FIFO.
  - Outputs: full, empty, head, per-entry valid and address vectors.

Test Plan:
- Single EX write: EX x5=0xDEADBEEF → cycle+1 rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; with raddr_a=5, fwd_a_o=1.
- Collision: issue load x7; then EX x3=0x11 together with lsu_rvalid 0x22 → ex_ready_o=0, write x7=0x22; next cycle x3=0x11 written.
- Hazard and full:
  - Issue loads x4 and x9 (NumOutstanding=2) → ld_issue_ready_o=0.
  - raddr_a=9 → hazard_a_o=1.
  - A third ld_issue_i is not accepted.
  - After both responses → hazards clear, ready=1.
- Errored and spurious responses:
  - Load x6 answered with lsu_err_i=1 → no write, ld_err_o one pulse, FIFO empty.
  - A further rvalid → spurious_o pulse and no write.
- Address suppression:
  - EX write to x0 → rf_we_o=0, or rf_we_o=1 with ex_dummy_i under IBEX_WB_DUMMY_R0_EN.
  - RV32E=1, EX write to x20 → rf_we_o=0.
- Reset with 2 loads outstanding → FIFO empty, hazards 0; subsequent rvalid → spurious_o.
